div_unit: RTL

- Multi-cycle 32-bit radix-2 divider in the EX stage, directly downstream of the main decoder.
- Consumes the decoder's startDiv, Sign and annul strobes together with the two EX operands.
- Produces a 64-bit {remainder, quotient} result that the HI/LO write path selects when DataToHI/DataToLO = 10.
- Exposes busy/ready so the hazard unit can stall the pipeline while a division is in flight.

---
 rtl/div_unit_pkg.sv | 22 ++
 rtl/div_step.sv | 27 ++
 rtl/div_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared state encoding and strobe levels for the EX-stage radix-2 divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Result sign corrections captured at start.
  typedef struct packed {
    logic qneg;
    logic rneg;
  } div_sign_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the {remainder, quotient} partial value.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  part,
  input  logic [WIDTH-1:0]  divisor,
  output logic [2*WIDTH:0]  part_nxt,
  output logic              qbit
);

  logic [2*WIDTH:0] sh;
  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   diff;
  logic             unused_msb;

  // Remainder is always below the divisor, so the top bit never carries information.
  assign unused_msb = part[2*WIDTH];

  always_comb begin
    sh       = {part[2*WIDTH-1:0], 1'b0};
    upper    = sh[2*WIDTH:WIDTH];
    diff     = upper - {1'b0, divisor};
    qbit     = (upper >= {1'b0, divisor});
    part_nxt = qbit ? {diff, sh[WIDTH-1:0]} : sh;
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider; result = {remainder, quotient}, ready pulses in END.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  div_state_e       state;
  logic [5:0]       cnt;
  logic [2*WIDTH:0] part;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] op1_q;
  div_sign_t        sg;

  logic [WIDTH-1:0] abs1, abs2;
  logic [2*WIDTH:0] part_nxt, part_new;
  logic             qbit;
  logic [WIDTH-1:0] q_fin, r_fin;

  assign abs1 = (sign && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs2 = (sign && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  div_step #(.WIDTH(WIDTH)) u_step (
    .part     (part),
    .divisor  (dvsr),
    .part_nxt (part_nxt),
    .qbit     (qbit)
  );

  assign part_new = part_nxt | {{(2*WIDTH){1'b0}}, qbit};
  assign q_fin    = sg.qneg ? -part_new[WIDTH-1:0]       : part_new[WIDTH-1:0];
  assign r_fin    = sg.rneg ? -part_new[2*WIDTH-1:WIDTH] : part_new[2*WIDTH-1:WIDTH];

  // Annul during END must suppress the pulse in the same cycle.
  assign ready = (state == DIV_END && !annul) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign busy  = (state != DIV_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      part   <= '0;
      dvsr   <= '0;
      op1_q  <= '0;
      sg     <= '0;
      result <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (!annul && start == DIV_START) begin
            op1_q   <= opdata1;
            dvsr    <= abs2;
            part    <= {{(WIDTH+1){1'b0}}, abs1};
            sg.qneg <= sign & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            sg.rneg <= sign & opdata1[WIDTH-1];
            cnt     <= '0;
            state   <= (opdata2 == '0) ? DIV_BYZERO : DIV_ON;
          end
        end
        DIV_BYZERO: begin
          if (annul) state <= DIV_IDLE;
          else begin
            result <= {op1_q, {WIDTH{1'b1}}};
            state  <= DIV_END;
          end
        end
        DIV_ON: begin
          if (annul) state <= DIV_IDLE;
          else begin
            part <= part_new;
            cnt  <= cnt + 6'd1;
            if (cnt == LAST) begin
              result <= {r_fin, q_fin};
              state  <= DIV_END;
            end
          end
        end
        DIV_END: state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
